// File: rtl/text_mem_arbiter_if.sv
// Bundles the requester, text-RAM and stream signals of text_mem_arbiter.
// slave = arbiter side, master = requester/RAM/consumer side.
interface text_mem_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 11,
    parameter int DATA_W = 8
);
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*LEN_W-1:0]  req_len;
    logic [NREQ-1:0]        grant;
    logic                   busy;
    logic [ADDR_W-1:0]      mem_addr;
    logic                   mem_rd;
    logic [DATA_W-1:0]      mem_data;
    logic [DATA_W-1:0]      out_data;
    logic                   out_valid;
    logic                   out_last;
    logic                   out_ready;
    logic [NREQ-1:0]        done;

    modport slave (
        input  req, req_addr, req_len, mem_data, out_ready,
        output grant, busy, mem_addr, mem_rd, out_data, out_valid, out_last, done
    );

    modport master (
        output req, req_addr, req_len, mem_data, out_ready,
        input  grant, busy, mem_addr, mem_rd, out_data, out_valid, out_last, done
    );
endinterface

// File: rtl/text_mem_arbiter.sv
// Shares the text RAM read port between NREQ requesters and streams one string at a time.
// Define TEXT_ARB_RR_EN for round-robin arbitration; default build is fixed priority.
module text_mem_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 11,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    text_mem_arbiter_if.slave bus
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_OUT, S_DONE} state_t;

    state_t            r_state,     w_state_nxt;
    logic [ADDR_W-1:0] r_cur_addr,  w_cur_addr_nxt;
    logic [LEN_W-1:0]  r_remaining, w_remaining_nxt;
    logic [ID_W-1:0]   r_id,        w_id_nxt;
    logic [NREQ-1:0]   r_grant,     w_grant_nxt;
    logic              r_busy,      w_busy_nxt;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic              r_mem_rd,    w_mem_rd_nxt;
    logic [DATA_W-1:0] r_out_data,  w_out_data_nxt;
    logic              r_out_valid, w_out_valid_nxt;
    logic              r_out_last,  w_out_last_nxt;
    logic [NREQ-1:0]   r_done,      w_done_nxt;

    logic [ID_W-1:0]   w_win;
    logic [ADDR_W-1:0] w_req_addr;
    logic [LEN_W-1:0]  w_req_len;

`ifdef TEXT_ARB_RR_EN
    logic [ID_W-1:0]   r_last;

    // Smallest offset from the last winner wins, so the last winner has lowest priority.
    always_comb begin
        int idx;
        w_win = '0;
        idx   = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(r_last) + k) % NREQ;
            if (bus.req[ID_W'(idx)]) w_win = ID_W'(idx);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  r_last <= ID_W'(NREQ - 1);
        else if (r_state == S_DONE) r_last <= r_id;
    end
`else
    always_comb begin
        w_win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) w_win = ID_W'(i);
        end
    end
`endif

    assign w_req_addr = bus.req_addr[w_win*ADDR_W +: ADDR_W];
    assign w_req_len  = bus.req_len[w_win*LEN_W +: LEN_W];

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        w_state_nxt     = r_state;
        w_cur_addr_nxt  = r_cur_addr;
        w_remaining_nxt = r_remaining;
        w_id_nxt        = r_id;
        w_grant_nxt     = r_grant;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_rd_nxt    = 1'b0;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        w_out_last_nxt  = r_out_last;
        w_done_nxt      = '0;

        unique case (r_state)
            S_IDLE: begin
                w_grant_nxt = '0;
                // The cycle carrying done is skipped so the finishing requester can drop req.
                if (r_done == '0 && |bus.req) begin
                    w_id_nxt        = w_win;
                    w_grant_nxt     = NREQ'(1) << w_win;
                    w_cur_addr_nxt  = w_req_addr;
                    w_remaining_nxt = w_req_len;
                    if (w_req_len == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt    = S_FETCH;
                        w_mem_rd_nxt   = 1'b1;
                        w_mem_addr_nxt = w_req_addr;
                    end
                end
            end
            S_FETCH: w_state_nxt = S_WAIT;
            S_WAIT: begin
                w_out_data_nxt  = bus.mem_data;
                w_out_valid_nxt = 1'b1;
                w_out_last_nxt  = (r_remaining == LEN_W'(1));
                w_state_nxt     = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_out_last_nxt  = 1'b0;
                    w_remaining_nxt = r_remaining - LEN_W'(1);
                    w_cur_addr_nxt  = r_cur_addr + ADDR_W'(1);
                    if (r_remaining == LEN_W'(1)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt    = S_FETCH;
                        w_mem_rd_nxt   = 1'b1;
                        w_mem_addr_nxt = r_cur_addr + ADDR_W'(1);
                    end
                end
            end
            S_DONE: begin
                w_done_nxt  = NREQ'(1) << r_id;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_id        <= '0;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_rd    <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= '0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            r_state     <= w_state_nxt;
            r_cur_addr  <= w_cur_addr_nxt;
            r_remaining <= w_remaining_nxt;
            r_id        <= w_id_nxt;
            r_grant     <= w_grant_nxt;
            r_busy      <= w_busy_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_rd    <= w_mem_rd_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_last_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign bus.grant     = r_grant;
    assign bus.busy      = r_busy;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_rd    = r_mem_rd;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_text_mem_arbiter.sv
// Self-checking bench for text_mem_arbiter: transaction-level model plus directed tests.
// Honours TEXT_ARB_RR_EN the same way the design does.
`timescale 1ns/1ps
module tb_text_mem_arbiter;
    localparam int NREQ   = 4;
    localparam int ADDR_W = 11;
    localparam int LEN_W  = 11;
    localparam int DATA_W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    text_mem_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) bus ();

    text_mem_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Text RAM contents: RAM[a] = a[7:0], one-cycle read latency.
    always @(posedge clk) begin
        if (reset)           bus.mem_data <= '0;
        else if (bus.mem_rd) bus.mem_data <= bus.mem_addr[7:0];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int last);
`ifdef TEXT_ARB_RR_EN
        for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
`else
        for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`endif
        return 0;
    endfunction

    // Request inputs as seen at the last active edge.
    logic [NREQ-1:0]        req_q;
    logic [NREQ*ADDR_W-1:0] raddr_q;
    logic [NREQ*LEN_W-1:0]  rlen_q;
    always @(posedge clk) begin
        req_q   <= reset ? '0 : bus.req;
        raddr_q <= bus.req_addr;
        rlen_q  <= bus.req_len;
    end

    // Model state: one transfer at a time, described by its string and progress.
    bit               act, m_vld, arb_ok;
    int               m_id, m_len, m_cnt, m_last;
    logic [ADDR_W-1:0] m_addr, ea;
    int               exp_rd, exp_vld, exp_done, cyc;
    logic [NREQ-1:0]  ed, prev_g;
    bit               prev_v;

    // Observations for the directed tests.
    logic [7:0]        obs_data[$];
    bit                obs_last[$];
    logic [ADDR_W-1:0] obs_addr[$];
    int                obs_done[$];
    int                grant_cyc, vld_cyc, done_cyc, gcnt;

    always @(negedge clk) begin
        if (reset) begin
            act = 0; m_vld = 0; arb_ok = 1; m_last = NREQ - 1;
            exp_rd = -10; exp_vld = -10; exp_done = -10;
            prev_g = '0; prev_v = 0;
        end else begin
            cyc++;
            if (!act) begin
                check("grant_rise", bus.grant != '0, arb_ok && req_q != '0);
                if (bus.grant != '0 && arb_ok && req_q != '0) begin
                    m_id   = pick(req_q, m_last);
                    check("grant_winner", bus.grant, NREQ'(1) << m_id);
                    act    = 1; m_vld = 0; m_cnt = 0;
                    m_addr = raddr_q[m_id*ADDR_W +: ADDR_W];
                    m_len  = int'(rlen_q[m_id*LEN_W +: LEN_W]);
                    if (m_len == 0) exp_done = cyc + 1;
                    else            exp_rd   = cyc;
                end
            end else begin
                check("grant_hold", bus.grant, NREQ'(1) << m_id);
            end
            check("busy", bus.busy, act && cyc != exp_done);

            ea = m_addr + ADDR_W'(m_cnt);
            check("mem_rd", bus.mem_rd, act && cyc == exp_rd);
            if (bus.mem_rd && act && cyc == exp_rd) begin
                check("mem_addr", bus.mem_addr, ea);
                exp_vld = cyc + 2;
            end
            if (cyc == exp_vld) m_vld = 1;
            check("out_valid", bus.out_valid, m_vld);
            if (m_vld) begin
                check("out_data", bus.out_data, ea[7:0]);
                check("out_last", bus.out_last, m_cnt == m_len - 1);
                if (bus.out_ready) begin
                    m_vld = 0;
                    m_cnt++;
                    if (m_cnt < m_len) exp_rd   = cyc + 1;
                    else               exp_done = cyc + 2;
                end
            end

            ed = (act && cyc == exp_done) ? NREQ'(1) << m_id : '0;
            check("done", bus.done, ed);
            if (ed != '0) begin
                act    = 0;
                m_last = m_id;
            end
            arb_ok = !act && ed == '0;

            if (bus.out_valid && bus.out_ready) begin
                obs_data.push_back(bus.out_data);
                obs_last.push_back(bus.out_last);
            end
            if (bus.mem_rd) obs_addr.push_back(bus.mem_addr);
            for (int i = 0; i < NREQ; i++) if (bus.done[i]) obs_done.push_back(i);
            if (bus.done != '0) done_cyc = cyc;
            if (bus.grant != '0 && prev_g == '0) grant_cyc = cyc;
            if (bus.out_valid && vld_cyc < 0) vld_cyc = cyc;
            if (bus.grant != '0) gcnt++;
            prev_g = bus.grant;
            prev_v = bus.out_valid;
        end
    end

    task automatic clear_obs();
        obs_data.delete(); obs_last.delete(); obs_addr.delete(); obs_done.delete();
        grant_cyc = -1; vld_cyc = -1; done_cyc = -1; gcnt = 0;
    endtask

    task automatic set_req(input int idx, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        bus.req_addr[idx*ADDR_W +: ADDR_W] = a;
        bus.req_len[idx*LEN_W +: LEN_W]    = l;
        bus.req[idx]                       = 1'b1;
    endtask

    task automatic wait_done(input int idx);
        bit seen = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (bus.done[idx]) begin seen = 1; break; end
        end
        check("done_timeout", seen, 1);
    endtask

    task automatic wait_valid();
        bit seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin seen = 1; break; end
        end
        check("valid_timeout", seen, 1);
    endtask

    task automatic wait_dones(input int n);
        bit seen = 0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            if (obs_done.size() >= n) begin seen = 1; break; end
        end
        check("dones_timeout", seen, 1);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int exp3[4];
        bus.req = '0; bus.req_addr = '0; bus.req_len = '0; bus.out_ready = 1'b1;
        clear_obs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", bus.grant, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_mem_rd", bus.mem_rd, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_done", bus.done, 0);
        reset = 1'b0;
        settle();

        // Basic three-byte string.
        clear_obs();
        set_req(0, 11'h010, 11'd3);
        wait_done(0);
        bus.req[0] = 1'b0;
        settle();
        check("t1_nbytes", obs_data.size(), 3);
        check("t1_byte0", obs_data[0], 8'h10);
        check("t1_byte1", obs_data[1], 8'h11);
        check("t1_byte2", obs_data[2], 8'h12);
        check("t1_last", {obs_last[0], obs_last[1], obs_last[2]}, 3'b001);
        check("t1_ndone", obs_done.size(), 1);
        check("t1_done_id", obs_done[0], 0);
        check("t1_latency", vld_cyc - grant_cyc, 2);

        // Zero-length string.
        clear_obs();
        set_req(2, 11'h055, 11'd0);
        wait_done(2);
        bus.req[2] = 1'b0;
        settle();
        check("t2_no_rd", obs_addr.size(), 0);
        check("t2_no_valid", vld_cyc, -1);
        check("t2_grant_cycles", gcnt, 2);
        check("t2_done_latency", done_cyc - grant_cyc, 1);

        // Two persistent requesters.
        clear_obs();
`ifdef TEXT_ARB_RR_EN
        exp3 = '{0, 1, 0, 1};
`else
        exp3 = '{0, 0, 0, 0};
`endif
        set_req(0, 11'h030, 11'd2);
        set_req(1, 11'h040, 11'd2);
        wait_dones(4);
        bus.req[0] = 1'b0;
        bus.req[1] = 1'b0;
        settle();
        for (int i = 0; i < 4; i++) check("t3_order", obs_done[i], exp3[i]);

        // Consumer back-pressure.
        clear_obs();
        bus.out_ready = 1'b0;
        set_req(0, 11'h1A0, 11'd3);
        wait_valid();
        repeat (5) @(posedge clk);
        #1;
        check("t4_hold_valid", bus.out_valid, 1);
        check("t4_hold_data", bus.out_data, 8'hA0);
        check("t4_hold_last", bus.out_last, 0);
        check("t4_hold_rd", bus.mem_rd, 0);
        bus.out_ready = 1'b1;
        wait_done(0);
        bus.req[0] = 1'b0;
        settle();
        check("t4_nbytes", obs_data.size(), 3);
        check("t4_bytes", {obs_data[0], obs_data[1], obs_data[2]}, 24'hA0A1A2);

        // Address wrap at the top of the RAM.
        clear_obs();
        set_req(0, 11'h7FF, 11'd2);
        wait_done(0);
        bus.req[0] = 1'b0;
        settle();
        check("t5_addr0", obs_addr[0], 11'h7FF);
        check("t5_addr1", obs_addr[1], 11'h000);
        check("t5_bytes", {obs_data[0], obs_data[1]}, 16'hFF00);
        check("t5_last", {obs_last[0], obs_last[1]}, 2'b01);

        // Asynchronous reset in the middle of a string.
        clear_obs();
        set_req(0, 11'h020, 11'd4);
        wait_valid();
        #2 reset = 1'b1;
        #1;
        check("t6_grant", bus.grant, 0);
        check("t6_busy", bus.busy, 0);
        check("t6_mem_rd", bus.mem_rd, 0);
        check("t6_mem_addr", bus.mem_addr, 0);
        check("t6_out_data", bus.out_data, 0);
        check("t6_out_valid", bus.out_valid, 0);
        check("t6_out_last", bus.out_last, 0);
        check("t6_done", bus.done, 0);
        set_req(3, 11'h060, 11'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        begin
            bit seen = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (bus.grant != '0) begin seen = 1; break; end
            end
            check("t6_grant_timeout", seen, 1);
        end
        check("t6_first_grant", bus.grant, 4'b0001);
        wait_done(0);
        bus.req[0] = 1'b0;
        wait_done(3);
        bus.req[3] = 1'b0;
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
